axi4l_ipif_multi: RTL and testbench

// - AXI4-Lite slave that fans out to C_NUM_CS register banks, each with its own chip select.
// - Decodes the address into a bank index and a local word address.
// - Adds DECERR for unmapped addresses and a parametrised ack timeout that responds SLVERR.
// - Sits between the interconnect and multiple peripheral register files; read and write paths are independent.

---
 rtl/axi4l_pkg.sv | 31 +++
 rtl/axi4l_ipif_multi_if.sv | 37 +++
 rtl/axi4l_ipif_timeout.sv | 19 +
 rtl/axi4l_ipif_multi.sv | 201 ++++++++++++++++++++
 tb/tb_axi4l_ipif_multi.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite response codes, FSM state types and the bank chip-select decoder
// used by the multi-bank IPIF.
package axi4l_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  // Upper bound on banks the decoder can express; the top checks C_NUM_CS against it.
  localparam int CS_MAX = 64;

  typedef struct packed {
    logic              vld;
    logic [CS_MAX-1:0] onehot;
  } cs_dec_t;

  typedef enum logic [2:0] {W_RST, W_IDLE, W_ADDR, W_DATA, W_WAIT, W_DEC, W_RESP} wr_state_t;
  typedef enum logic [2:0] {R_RST, R_IDLE, R_WAIT, R_DEC, R_RESP} rd_state_t;

  function automatic cs_dec_t cs_decode(input int unsigned idx, input int unsigned num_cs);
    cs_dec_t d;
    d = '0;
    if (idx < num_cs && idx < CS_MAX) begin
      d.vld    = 1'b1;
      d.onehot = {{(CS_MAX-1){1'b0}}, 1'b1} << idx;
    end
    return d;
  endfunction

endpackage

// File: rtl/axi4l_ipif_multi_if.sv
// AXI4-Lite bus bundle between the interconnect (master) and the IPIF (slave).
interface axi4l_ipif_multi_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi4l_ipif_timeout.sv
// Ack watchdog: counts enabled cycles and flags when the counter saturates.
module axi4l_ipif_timeout #(
  parameter int C_TIMEOUT_WIDTH = 5
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [C_TIMEOUT_WIDTH-1:0] cnt;

  always_ff @(posedge aclk) begin
    if (!aresetn || clr) cnt <= '0;
    else if (en)         cnt <= cnt + 1'b1;
  end

  assign expired = &cnt;
endmodule

// File: rtl/axi4l_ipif_multi.sv
// AXI4-Lite slave fanning out to C_NUM_CS register banks with per-bank chip selects,
// DECERR on unmapped banks and SLVERR on ack timeout. Read and write paths are independent.
module axi4l_ipif_multi
  import axi4l_pkg::*;
#(
  parameter int C_ADDR_WIDTH    = 16,
  parameter int C_DATA_WIDTH    = 32,
  parameter int C_NUM_CS        = 4,
  parameter int C_REGION_BITS   = 12,
  parameter int C_TIMEOUT_WIDTH = 5,
  parameter logic [C_DATA_WIDTH-1:0] C_ERR_RDATA = '0
) (
  input  logic                             aclk,
  input  logic                             aresetn,
  axi4l_ipif_multi_if.slave                s_axi,
  output logic [C_NUM_CS-1:0]              wr_cs,
  output logic [C_REGION_BITS-3:0]         wr_addr,
  output logic                             wr_req,
  output logic [C_DATA_WIDTH/8-1:0]        wr_be,
  output logic [C_DATA_WIDTH-1:0]          wr_data,
  input  logic [C_NUM_CS-1:0]              wr_ack,
  output logic [C_NUM_CS-1:0]              rd_cs,
  output logic [C_REGION_BITS-3:0]         rd_addr,
  output logic                             rd_req,
  input  logic [C_NUM_CS*C_DATA_WIDTH-1:0] rd_data,
  input  logic [C_NUM_CS-1:0]              rd_ack
);
  localparam int IDX_W = C_ADDR_WIDTH - C_REGION_BITS;

  if (C_DATA_WIDTH != 32 && C_DATA_WIDTH != 64) begin : g_err_dw
    $error("axi4l_ipif_multi: C_DATA_WIDTH must be 32 or 64");
  end
  if (C_REGION_BITS < 3 || C_REGION_BITS >= C_ADDR_WIDTH) begin : g_err_rb
    $error("axi4l_ipif_multi: C_REGION_BITS out of range");
  end
  if (C_NUM_CS < 1 || C_NUM_CS > CS_MAX || C_NUM_CS > (1 << IDX_W)) begin : g_err_cs
    $error("axi4l_ipif_multi: C_NUM_CS out of range");
  end

  // ---------------- write path ----------------
  wr_state_t        wst, wst_nxt;
  logic             aw_hs, w_hs, wr_hit, wr_to;
  logic [IDX_W-1:0] aw_idx, aw_idx_q;
  cs_dec_t          aw_dec;

  assign aw_hs  = s_axi.awvalid & s_axi.awready;
  assign w_hs   = s_axi.wvalid & s_axi.wready;
  // Decode the live address on the AW handshake, otherwise the one captured earlier.
  assign aw_idx = aw_hs ? s_axi.awaddr[C_ADDR_WIDTH-1:C_REGION_BITS] : aw_idx_q;
  assign aw_dec = cs_decode(32'(aw_idx), C_NUM_CS);
  assign wr_hit = |(wr_ack & wr_cs);

  always_ff @(posedge aclk) begin
    if (!aresetn) wst <= W_RST;
    else          wst <= wst_nxt;
  end

  always_comb begin
    wst_nxt = wst;
    case (wst)
      W_RST:  wst_nxt = W_IDLE;
      W_IDLE: begin
        if (aw_hs && w_hs) wst_nxt = aw_dec.vld ? W_WAIT : W_DEC;
        else if (aw_hs)    wst_nxt = W_ADDR;
        else if (w_hs)     wst_nxt = W_DATA;
      end
      W_ADDR: if (w_hs)  wst_nxt = aw_dec.vld ? W_WAIT : W_DEC;
      W_DATA: if (aw_hs) wst_nxt = aw_dec.vld ? W_WAIT : W_DEC;
      W_WAIT: if (wr_hit || wr_to) wst_nxt = W_RESP;
      W_DEC:  wst_nxt = W_RESP;
      W_RESP: if (s_axi.bready) wst_nxt = W_IDLE;
      default: wst_nxt = W_RST;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi.awready <= 1'b0;
      s_axi.wready  <= 1'b0;
      s_axi.bvalid  <= 1'b0;
      s_axi.bresp   <= OKAY;
      aw_idx_q      <= '0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_be         <= '0;
      wr_req        <= 1'b0;
      wr_cs         <= '0;
    end else begin
      s_axi.awready <= (wst_nxt == W_IDLE) || (wst_nxt == W_DATA);
      s_axi.wready  <= (wst_nxt == W_IDLE) || (wst_nxt == W_ADDR);
      wr_req        <= 1'b0;
      if (aw_hs) begin
        aw_idx_q <= s_axi.awaddr[C_ADDR_WIDTH-1:C_REGION_BITS];
        wr_addr  <= s_axi.awaddr[C_REGION_BITS-1:2];
      end
      if (w_hs) begin
        wr_data <= s_axi.wdata;
        wr_be   <= s_axi.wstrb;
      end
      if (wst != W_WAIT && wst_nxt == W_WAIT) begin
        wr_req <= 1'b1;
        wr_cs  <= aw_dec.onehot[C_NUM_CS-1:0];
      end else if (wst_nxt != W_WAIT) begin
        wr_cs <= '0;
      end
      // Ack has priority over a coincident timeout.
      if (wst != W_RESP && wst_nxt == W_RESP) begin
        s_axi.bvalid <= 1'b1;
        s_axi.bresp  <= (wst == W_DEC) ? DECERR : (wr_hit ? OKAY : SLVERR);
      end else if (wst_nxt != W_RESP) begin
        s_axi.bvalid <= 1'b0;
        s_axi.bresp  <= OKAY;
      end
    end
  end

  axi4l_ipif_timeout #(.C_TIMEOUT_WIDTH(C_TIMEOUT_WIDTH)) u_wr_to (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (wst != W_WAIT),
    .en      (wst == W_WAIT),
    .expired (wr_to)
  );

  // ---------------- read path ----------------
  rd_state_t               rst_q, rst_nxt;
  logic                    ar_hs, rd_hit, rd_to;
  cs_dec_t                 ar_dec;
  logic [C_DATA_WIDTH-1:0] rd_mux;

  assign ar_hs  = s_axi.arvalid & s_axi.arready;
  assign ar_dec = cs_decode(32'(s_axi.araddr[C_ADDR_WIDTH-1:C_REGION_BITS]), C_NUM_CS);
  assign rd_hit = |(rd_ack & rd_cs);

  always_comb begin
    rd_mux = '0;
    for (int i = 0; i < C_NUM_CS; i++)
      if (rd_cs[i]) rd_mux = rd_mux | rd_data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) rst_q <= R_RST;
    else          rst_q <= rst_nxt;
  end

  always_comb begin
    rst_nxt = rst_q;
    case (rst_q)
      R_RST:  rst_nxt = R_IDLE;
      R_IDLE: if (ar_hs) rst_nxt = ar_dec.vld ? R_WAIT : R_DEC;
      R_WAIT: if (rd_hit || rd_to) rst_nxt = R_RESP;
      R_DEC:  rst_nxt = R_RESP;
      R_RESP: if (s_axi.rready) rst_nxt = R_IDLE;
      default: rst_nxt = R_RST;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      s_axi.arready <= 1'b0;
      s_axi.rvalid  <= 1'b0;
      s_axi.rresp   <= OKAY;
      s_axi.rdata   <= '0;
      rd_addr       <= '0;
      rd_req        <= 1'b0;
      rd_cs         <= '0;
    end else begin
      s_axi.arready <= (rst_nxt == R_IDLE);
      rd_req        <= 1'b0;
      if (ar_hs) rd_addr <= s_axi.araddr[C_REGION_BITS-1:2];
      if (rst_q != R_WAIT && rst_nxt == R_WAIT) begin
        rd_req <= 1'b1;
        rd_cs  <= ar_dec.onehot[C_NUM_CS-1:0];
      end else if (rst_nxt != R_WAIT) begin
        rd_cs <= '0;
      end
      if (rst_q != R_RESP && rst_nxt == R_RESP) begin
        s_axi.rvalid <= 1'b1;
        s_axi.rresp  <= (rst_q == R_DEC) ? DECERR : (rd_hit ? OKAY : SLVERR);
        s_axi.rdata  <= rd_hit ? rd_mux : C_ERR_RDATA;
      end else if (rst_nxt != R_RESP) begin
        s_axi.rvalid <= 1'b0;
        s_axi.rresp  <= OKAY;
        s_axi.rdata  <= '0;
      end
    end
  end

  axi4l_ipif_timeout #(.C_TIMEOUT_WIDTH(C_TIMEOUT_WIDTH)) u_rd_to (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clr     (rst_q != R_WAIT),
    .en      (rst_q == R_WAIT),
    .expired (rd_to)
  );

  logic unused_ok;
  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0],
                       aw_dec, ar_dec};

endmodule

// File: tb/tb_axi4l_ipif_multi.sv
// Scenario bench for axi4l_ipif_multi: expected B/R responses queued at stimulus, checked on output.
module tb_axi4l_ipif_multi;
  import axi4l_pkg::*;

  logic         aclk = 1'b0;
  logic         aresetn = 1'b0;
  logic [3:0]   wr_cs, wr_ack, rd_cs, rd_ack;
  logic [9:0]   wr_addr, rd_addr;
  logic         wr_req, rd_req;
  logic [3:0]   wr_be;
  logic [31:0]  wr_data;
  logic [127:0] rd_data;

  axi4l_ipif_multi_if #(.ADDR_W(16), .DATA_W(32)) axi ();

  axi4l_ipif_multi dut (
    .aclk(aclk), .aresetn(aresetn), .s_axi(axi),
    .wr_cs(wr_cs), .wr_addr(wr_addr), .wr_req(wr_req), .wr_be(wr_be), .wr_data(wr_data),
    .wr_ack(wr_ack), .rd_cs(rd_cs), .rd_addr(rd_addr), .rd_req(rd_req),
    .rd_data(rd_data), .rd_ack(rd_ack)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0;
  int n_fail = 0;
  int wr_req_n = 0;
  int rd_req_n = 0;
  logic [1:0]  exp_b_q[$];
  logic [1:0]  exp_r_q[$];
  logic [31:0] exp_d_q[$];

  logic [106:0] all_outs;
  assign all_outs = {axi.awready, axi.wready, axi.arready, axi.bvalid, axi.rvalid,
                     axi.bresp, axi.rresp, axi.rdata, wr_cs, wr_req, wr_addr, wr_be,
                     wr_data, rd_cs, rd_req, rd_addr};

  always @(negedge aclk) begin
    if (wr_req === 1'b1) wr_req_n++;
    if (rd_req === 1'b1) rd_req_n++;
  end

  task automatic tick;
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 50; i++) begin
      if (axi.awready && axi.wready && axi.arready) break;
      tick();
    end
  endtask

  task automatic drive_aw(input logic [15:0] a);
    axi.awaddr = a; axi.awvalid = 1'b1;
  endtask

  task automatic drive_w(input logic [31:0] d, input logic [3:0] s);
    axi.wdata = d; axi.wstrb = s; axi.wvalid = 1'b1;
  endtask

  task automatic test_reset;
    tick(); tick();
    n_chk++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL reset_outs: got %h want 0", all_outs);
    end
    aresetn = 1'b1;
    tick();
    n_chk++;
    if (all_outs !== {3'b111, 104'b0}) begin
      n_fail++; $display("FAIL reset_release: got %h want readies only", all_outs);
    end
  endtask

  task automatic test_aligned_write;
    int n0;
    logic [1:0] e;
    n0 = wr_req_n;
    drive_aw(16'h1008); drive_w(32'hA5A5_0001, 4'hF);
    exp_b_q.push_back(OKAY);
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n_chk++;
    if ({wr_cs, wr_addr, wr_req} !== {4'b0010, 10'h002, 1'b1}) begin
      n_fail++; $display("FAIL aw_strobe: got cs=%b addr=%h req=%b want 0010 002 1", wr_cs, wr_addr, wr_req);
    end
    n_chk++;
    if ({wr_data, wr_be} !== {32'hA5A5_0001, 4'hF}) begin
      n_fail++; $display("FAIL aw_data: got %h/%h want a5a50001/f", wr_data, wr_be);
    end
    tick(); tick(); tick();
    n_chk++;
    if ({axi.bvalid, wr_cs} !== {1'b0, 4'b0010}) begin
      n_fail++; $display("FAIL aw_hold: got bvalid=%b cs=%b want 0 0010", axi.bvalid, wr_cs);
    end
    wr_ack = 4'b0010;
    tick();
    wr_ack = 4'b0000;
    e = exp_b_q.pop_front();
    n_chk++;
    if ({axi.bvalid, axi.bresp} !== {1'b1, e}) begin
      n_fail++; $display("FAIL aw_bresp: got bvalid=%b bresp=%b want 1 %b", axi.bvalid, axi.bresp, e);
    end
    n_chk++;
    if (wr_req_n - n0 !== 1) begin
      n_fail++; $display("FAIL aw_req_count: got %0d want 1", wr_req_n - n0);
    end
    tick(); wait_idle();
  endtask

  task automatic test_split_write;
    logic [1:0] e;
    drive_w(32'hDEAD_BEEF, 4'h3);
    exp_b_q.push_back(OKAY);
    tick();
    axi.wvalid = 1'b0;
    n_chk++;
    if ({axi.awready, axi.wready, wr_req} !== 3'b100) begin
      n_fail++; $display("FAIL split_data_state: got aw/w/req=%b%b%b want 100", axi.awready, axi.wready, wr_req);
    end
    tick(); tick(); tick(); tick();
    drive_aw(16'h3FFC);
    tick();
    axi.awvalid = 1'b0;
    n_chk++;
    if ({wr_cs, wr_addr, wr_req, wr_data, wr_be} !== {4'b1000, 10'h3FF, 1'b1, 32'hDEAD_BEEF, 4'h3}) begin
      n_fail++; $display("FAIL split_strobe: got cs=%b addr=%h req=%b data=%h be=%h", wr_cs, wr_addr, wr_req, wr_data, wr_be);
    end
    wr_ack = 4'b1000;
    n_chk++;
    if (axi.bvalid !== 1'b0) begin
      n_fail++; $display("FAIL split_early_b: got bvalid=%b want 0", axi.bvalid);
    end
    tick();
    wr_ack = 4'b0000;
    e = exp_b_q.pop_front();
    n_chk++;
    if ({axi.bvalid, axi.bresp} !== {1'b1, e}) begin
      n_fail++; $display("FAIL split_bresp: got bvalid=%b bresp=%b want 1 %b", axi.bvalid, axi.bresp, e);
    end
    tick(); wait_idle();
  endtask

  task automatic test_unmapped_read;
    int n0;
    logic [1:0] e;
    logic [31:0] d;
    n0 = rd_req_n;
    axi.araddr = 16'h4000; axi.arvalid = 1'b1;
    exp_r_q.push_back(DECERR); exp_d_q.push_back(32'h0);
    tick();
    axi.arvalid = 1'b0;
    n_chk++;
    if ({rd_req, rd_cs, axi.rvalid} !== 6'b0) begin
      n_fail++; $display("FAIL dec_no_req: got req=%b cs=%b rvalid=%b want 0", rd_req, rd_cs, axi.rvalid);
    end
    tick();
    e = exp_r_q.pop_front(); d = exp_d_q.pop_front();
    n_chk++;
    if ({axi.rvalid, axi.rresp, axi.rdata} !== {1'b1, e, d}) begin
      n_fail++; $display("FAIL dec_resp: got rvalid=%b rresp=%b rdata=%h want 1 %b %h", axi.rvalid, axi.rresp, axi.rdata, e, d);
    end
    n_chk++;
    if (rd_req_n !== n0) begin
      n_fail++; $display("FAIL dec_req_count: got %0d want %0d", rd_req_n, n0);
    end
    tick(); wait_idle();
  endtask

  task automatic test_timeout;
    int nwait;
    bit seen;
    logic [1:0] e;
    nwait = 0; seen = 0;
    drive_aw(16'h0000); drive_w(32'h0000_0042, 4'hF);
    exp_b_q.push_back(SLVERR);
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (axi.bvalid) begin seen = 1; break; end
      if (wr_cs == 4'b0001) nwait++;
      tick();
    end
    n_chk++;
    if (!seen || nwait != 32) begin
      n_fail++; $display("FAIL to_cycles: got seen=%0d wait=%0d want 1 32", seen, nwait);
    end
    e = exp_b_q.pop_front();
    n_chk++;
    if (axi.bresp !== e) begin
      n_fail++; $display("FAIL to_bresp: got %b want %b", axi.bresp, e);
    end
    wr_ack = 4'b0001;
    tick(); tick();
    wr_ack = 4'b0000;
    n_chk++;
    if ({axi.bvalid, wr_cs} !== 5'b0) begin
      n_fail++; $display("FAIL to_late_ack: got bvalid=%b cs=%b want 0", axi.bvalid, wr_cs);
    end
    wait_idle();
    drive_aw(16'h0004); drive_w(32'h0000_0043, 4'hF);
    exp_b_q.push_back(OKAY);
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    wr_ack = 4'b0001;
    tick();
    wr_ack = 4'b0000;
    e = exp_b_q.pop_front();
    n_chk++;
    if ({axi.bvalid, axi.bresp} !== {1'b1, e}) begin
      n_fail++; $display("FAIL to_next_write: got bvalid=%b bresp=%b want 1 %b", axi.bvalid, axi.bresp, e);
    end
    tick(); wait_idle();
  endtask

  task automatic test_backpressure;
    int n0;
    logic [1:0] eb, er;
    logic [31:0] ed;
    n0 = rd_req_n;
    axi.bready = 1'b0; axi.rready = 1'b0;
    axi.araddr = 16'h2010; axi.arvalid = 1'b1;
    drive_aw(16'h2014); drive_w(32'h0BAD_F00D, 4'hF);
    exp_r_q.push_back(OKAY); exp_d_q.push_back(32'h1234_5678); exp_b_q.push_back(OKAY);
    tick();
    axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n_chk++;
    if ({rd_cs, rd_addr, wr_cs, wr_addr} !== {4'b0100, 10'h004, 4'b0100, 10'h005}) begin
      n_fail++; $display("FAIL bp_cs: got rcs=%b raddr=%h wcs=%b waddr=%h", rd_cs, rd_addr, wr_cs, wr_addr);
    end
    rd_ack = 4'b0100; wr_ack = 4'b0100;
    tick();
    rd_ack = 4'b0000; wr_ack = 4'b0000;
    eb = exp_b_q.pop_front(); er = exp_r_q.pop_front(); ed = exp_d_q.pop_front();
    n_chk++;
    if ({axi.rvalid, axi.rresp, axi.rdata, axi.bvalid, axi.bresp} !== {1'b1, er, ed, 1'b1, eb}) begin
      n_fail++; $display("FAIL bp_resp: got r=%b/%b/%h b=%b/%b want 1/%b/%h 1/%b", axi.rvalid, axi.rresp, axi.rdata, axi.bvalid, axi.bresp, er, ed, eb);
    end
    rd_data[64 +: 32] = 32'hFFFF_FFFF;
    axi.araddr = 16'h0000; axi.arvalid = 1'b1;
    drive_aw(16'h0000); drive_w(32'h0, 4'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      n_chk++;
      if ({axi.rvalid, axi.bvalid, axi.rdata, axi.awready, axi.wready, axi.arready} !== {2'b11, ed, 3'b000}) begin
        n_fail++; $display("FAIL bp_hold%0d: got rv=%b bv=%b rdata=%h rdy=%b%b%b", i, axi.rvalid, axi.bvalid, axi.rdata, axi.awready, axi.wready, axi.arready);
      end
    end
    axi.arvalid = 1'b0; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    axi.bready = 1'b1; axi.rready = 1'b1;
    tick();
    n_chk++;
    if ({axi.rvalid, axi.bvalid, axi.awready, axi.arready} !== 4'b0011 || rd_req_n - n0 !== 1) begin
      n_fail++; $display("FAIL bp_release: got rv=%b bv=%b awr=%b arr=%b reqs=%0d", axi.rvalid, axi.bvalid, axi.awready, axi.arready, rd_req_n - n0);
    end
    rd_data[64 +: 32] = 32'h1234_5678;
    wait_idle();
  endtask

  task automatic test_reset_mid;
    drive_aw(16'h1000); drive_w(32'h5555_AAAA, 4'hF);
    axi.araddr = 16'h1000; axi.arvalid = 1'b1;
    tick();
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    tick();
    aresetn = 1'b0;
    tick();
    n_chk++;
    if (all_outs !== '0) begin
      n_fail++; $display("FAIL rst_mid_outs: got %h want 0", all_outs);
    end
    aresetn = 1'b1;
    tick();
    n_chk++;
    if (all_outs !== {3'b111, 104'b0}) begin
      n_fail++; $display("FAIL rst_mid_release: got %h want readies only", all_outs);
    end
  endtask

  initial begin
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b1;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b1;
    wr_ack = '0; rd_ack = '0;
    rd_data = {32'hB3B3_0003, 32'h1234_5678, 32'hB1B1_0001, 32'hB0B0_0000};
    test_reset();
    test_aligned_write();
    test_split_write();
    test_unmapped_read();
    test_timeout();
    test_backpressure();
    test_reset_mid();
    n_chk++;
    if (exp_b_q.size() != 0 || exp_r_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got b=%0d r=%0d left want 0", exp_b_q.size(), exp_r_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
